// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan gate checker.
package demorgan_pkg;

  localparam int unsigned NUM_COMBOS  = 4;
  localparam int unsigned ERR_FLAGS_W = 6;

  // Bit positions inside err_flags / the gate vector, MSB first
  localparam int unsigned ERR_N_A       = 5;
  localparam int unsigned ERR_N_B       = 4;
  localparam int unsigned ERR_NA_AND_NB = 3;
  localparam int unsigned ERR_NA_OR_NB  = 2;
  localparam int unsigned ERR_A_NAND_B  = 1;
  localparam int unsigned ERR_A_NOR_B   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Six gate outputs, packed in err_flags order
  typedef struct packed {
    logic n_a;
    logic n_b;
    logic na_and_nb;
    logic na_or_nb;
    logic a_nand_b;
    logic a_nor_b;
  } gate_vec_t;

endpackage

// File: rtl/demorgan_ref.sv
// Golden combinational model of the two-input De Morgan gate block.
module demorgan_ref
  import demorgan_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output gate_vec_t expected_c
);

  // Each identity evaluated directly on {a,b}
  always_comb begin
    expected_c           = '0;
    expected_c.n_a       = ~a;
    expected_c.n_b       = ~b;
    expected_c.na_and_nb = ~(a | b);
    expected_c.na_or_nb  = ~(a & b);
    expected_c.a_nand_b  = ~(a & b);
    expected_c.a_nor_b   = ~(a | b);
  end

endmodule

// File: rtl/demorgan_checker.sv
// Self-checking responder for the De Morgan gate block: compares each
// handshaked sample against the reference identities, tracks coverage of
// the four input combinations and reports a pass/fail/timeout verdict.
module demorgan_checker
  import demorgan_pkg::*;
#(
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   vld,
  output logic                   rdy,
  input  logic                   a,
  input  logic                   b,
  input  logic                   n_a,
  input  logic                   n_b,
  input  logic                   na_and_nb,
  input  logic                   na_or_nb,
  input  logic                   a_nand_b,
  input  logic                   a_nor_b,
  output logic [ERR_FLAGS_W-1:0] err_flags,
  output logic [ERR_W-1:0]       err_count,
  output logic [NUM_COMBOS-1:0]  cov,
  output logic [2:0]             first_err,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t                 state_q, state_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [ERR_FLAGS_W-1:0] err_flags_d;
  logic [ERR_W-1:0]       err_count_d;
  logic [NUM_COMBOS-1:0]  cov_d;
  logic [2:0]             first_err_d;
  logic                   done_d, pass_d, timed_out_d;

  gate_vec_t              expected_c;
  gate_vec_t              observed_c;
  logic [ERR_FLAGS_W-1:0] diff_c;
  logic                   any_err_c;
  logic                   accept_c;
  logic [ERR_W-1:0]       err_count_acc_c;
  logic [NUM_COMBOS-1:0]  cov_acc_c;

  demorgan_ref u_ref (
    .a          (a),
    .b          (b),
    .expected_c (expected_c)
  );

  assign observed_c = {n_a, n_b, na_and_nb, na_or_nb, a_nand_b, a_nor_b};

  // start has priority over any sample presented in the same cycle
  assign rdy      = (state_q == ST_COLLECT) && !start;
  assign accept_c = vld && rdy;

  // Next-state and next-result logic
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    err_flags_d = err_flags;
    err_count_d = err_count;
    cov_d       = cov;
    first_err_d = first_err;
    done_d      = done;
    pass_d      = pass;
    timed_out_d = timed_out;

    diff_c    = observed_c ^ expected_c;
    any_err_c = |diff_c;

    err_count_acc_c = err_count;
    if (any_err_c && (err_count != ERR_MAX)) begin
      err_count_acc_c = err_count + ERR_W'(1);
    end
    cov_acc_c = cov | (NUM_COMBOS'(1) << {a, b});

    if (start) begin
      state_d     = ST_COLLECT;
      tmo_d       = '0;
      err_flags_d = '0;
      err_count_d = '0;
      cov_d       = '0;
      first_err_d = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      timed_out_d = 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (accept_c) begin
            err_flags_d = diff_c;
            err_count_d = err_count_acc_c;
            cov_d       = cov_acc_c;
            if (!first_err[2] && any_err_c) begin
              first_err_d = {1'b1, a, b};
            end
          end
          // A completing accept beats a coincident timeout
          if (accept_c && (cov_acc_c == '1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_count_acc_c == '0);
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            timed_out_d = 1'b1;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      err_flags <= '0;
      err_count <= '0;
      cov       <= '0;
      first_err <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      err_flags <= err_flags_d;
      err_count <= err_count_d;
      cov       <= cov_d;
      first_err <= first_err_d;
      done      <= done_d;
      pass      <= pass_d;
      timed_out <= timed_out_d;
    end
  end

endmodule
